// File: rtl/vol_btn_pkg.sv
// Shared definitions for the volume button conditioner and volume_buttons:
// inc_dec command encodings, per-button FSM states and the debug view.
package vol_btn_pkg;

  localparam logic [1:0] INC_DEC_NONE = 2'b00;
  localparam logic [1:0] INC_DEC_DEC  = 2'b01;
  localparam logic [1:0] INC_DEC_INC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Snapshot of both press/repeat FSMs, exported for observation.
  typedef struct packed {
    state_e up_state;
    state_e down_state;
  } dbg_t;

endpackage

// File: rtl/volume_button_conditioner_if.sv
// One button channel: raw level in, debounced level, command strobe and
// FSM state out.
//
// The pulse is a single-cycle strobe with no back-pressure. A consumer
// sees exactly one command for each cycle in which pulse is high. There
// is no ready signal: the downstream side always accepts.
interface volume_button_conditioner_if;

  logic                raw;
  logic                db;
  logic                pulse;
  vol_btn_pkg::state_e state;

  // Channel logic side: consumes the raw button and produces everything else.
  modport master (
    input  raw,
    output db,
    output pulse,
    output state
  );

  // Owner side: feeds the raw button and observes the conditioned results.
  modport slave (
    output raw,
    input  db,
    input  pulse,
    input  state
  );

endinterface

// File: rtl/button_debounce_repeat.sv
// Per-button conditioning: 2-flop synchronizer, debounce filter that needs
// DEBOUNCE_CYCLES consecutive disagreeing samples to change level, and a
// press/auto-repeat FSM producing a combinational single-cycle pulse.
module button_debounce_repeat
  import vol_btn_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic                          clk,
  input  logic                          rst,
  volume_button_conditioner_if.master   ch
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        db_q, db_d;
  logic        db_prev_q, db_prev_d;
  logic [15:0] dcnt_q, dcnt_d;
  state_e      state_q, state_d;
  logic [23:0] rcnt_q, rcnt_d;
  logic        pulse;

  // Two-stage synchronizer for the asynchronous raw button.
  always_comb begin
    sync1_d = ch.raw;
    sync2_d = sync1_q;
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronized samples disagree with the current level.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    if (sync2_q == db_q) begin
      dcnt_d = 16'd0;
    end else if (dcnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      db_d   = sync2_q;
      dcnt_d = 16'd0;
    end else begin
      dcnt_d = dcnt_q + 16'd1;
    end
  end

  // Press/auto-repeat FSM: first pulse on the debounced rising edge, one
  // after REPEAT_DELAY, then one every REPEAT_PERIOD while held.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    pulse     = 1'b0;
    db_prev_d = db_q;
    case (state_q)
      IDLE: begin
        if (db_q && !db_prev_q) begin
          pulse   = 1'b1;
          rcnt_d  = 24'd0;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (!db_q) begin
          rcnt_d  = 24'd0;
          state_d = IDLE;
        end else if (rcnt_q == REPEAT_DELAY - 24'd1) begin
          pulse   = 1'b1;
          rcnt_d  = 24'd0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 24'd1;
        end
      end
      REPEAT: begin
        if (!db_q) begin
          rcnt_d  = 24'd0;
          state_d = IDLE;
        end else if (rcnt_q == REPEAT_PERIOD - 24'd1) begin
          pulse  = 1'b1;
          rcnt_d = 24'd0;
        end else begin
          rcnt_d = rcnt_q + 24'd1;
        end
      end
      default: begin
        rcnt_d  = 24'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= 16'd0;
      state_q   <= IDLE;
      rcnt_q    <= 24'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign ch.db    = db_q;
  assign ch.pulse = pulse;
  assign ch.state = state_q;

endmodule

// File: rtl/volume_button_conditioner.sv
// Conditions raw up/down volume buttons into registered inc_dec commands.
// A channel's pulses are dropped while the other button is debounced-held,
// so simultaneous presses yield no command and 2'b11 cannot occur.
module volume_button_conditioner
  import vol_btn_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] inc_dec,
  output logic       up_held,
  output logic       down_held,
  output dbg_t       dbg_state
);

  volume_button_conditioner_if up_ch ();
  volume_button_conditioner_if dn_ch ();

  logic [1:0] inc_dec_q, inc_dec_d;

  assign up_ch.raw = btn_up;
  assign dn_ch.raw = btn_down;

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk (clk),
    .rst (rst),
    .ch  (up_ch.master)
  );

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dn (
    .clk (clk),
    .rst (rst),
    .ch  (dn_ch.master)
  );

  // Merge: each channel's pulse is masked by the other's debounced level.
  always_comb begin
    inc_dec_d = INC_DEC_NONE;
    if (up_ch.pulse && !dn_ch.db) begin
      inc_dec_d = inc_dec_d | INC_DEC_INC;
    end
    if (dn_ch.pulse && !up_ch.db) begin
      inc_dec_d = inc_dec_d | INC_DEC_DEC;
    end
  end

  // Output command register.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_dec_q <= INC_DEC_NONE;
    end else begin
      inc_dec_q <= inc_dec_d;
    end
  end

  assign inc_dec              = inc_dec_q;
  assign up_held              = up_ch.db;
  assign down_held            = dn_ch.db;
  assign dbg_state.up_state   = up_ch.state;
  assign dbg_state.down_state = dn_ch.state;

endmodule

// File: tb/tb_volume_button_conditioner.sv
// Bench for volume_button_conditioner: directed scenarios followed by
// random button activity, checked cycle by cycle against a timing model.
module tb_volume_button_conditioner;
  import vol_btn_pkg::*;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] inc_dec;
  dbg_t       dbg;

  always #5 clk = ~clk;

  volume_button_conditioner_if up_if ();
  volume_button_conditioner_if dn_if ();

  assign up_if.pulse = inc_dec[1];
  assign dn_if.pulse = inc_dec[0];
  assign up_if.state = dbg.up_state;
  assign dn_if.state = dbg.down_state;

  volume_button_conditioner #(
    .DEBOUNCE_CYCLES (16'(D)),
    .REPEAT_DELAY    (24'(RD)),
    .REPEAT_PERIOD   (24'(RP))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (up_if.raw),
    .btn_down  (dn_if.raw),
    .inc_dec   (inc_dec),
    .up_held   (up_if.db),
    .down_held (dn_if.db),
    .dbg_state (dbg)
  );

  // ---------------- scoreboard state ----------------
  // Entry: {reset_edge, inc, dec, up_held, down_held}
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Debounced level flips once the last D synchronizer outputs all disagree
  // with it. A press first sampled after edge m-1 gives a first pulse at
  // T = m+1, then pulses at T+RD+k*RP while the level stays high.
  int m_edge = 0;
  bit r1 [2];
  bit r2 [2];
  bit mdb [2];
  bit win [2][D];
  int nfill [2];
  int t0 [2];
  bit raw_now [2];
  bit vis [2];
  bit s_in;
  bit all_diff;

  initial begin
    for (int c = 0; c < 2; c++) begin
      r1[c] = 1'b0; r2[c] = 1'b0; mdb[c] = 1'b0; nfill[c] = 0; t0[c] = -1;
    end
    forever begin
      @(posedge clk);
      m_edge++;
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          r1[c] = 1'b0; r2[c] = 1'b0; mdb[c] = 1'b0; nfill[c] = 0; t0[c] = -1;
        end
        exp_q.push_back({1'b1, 2'b00, 1'b0, 1'b0});
      end else begin
        raw_now[0] = up_if.raw;
        raw_now[1] = dn_if.raw;
        for (int c = 0; c < 2; c++) begin
          vis[c] = mdb[c] && (t0[c] >= 0) &&
                   ((m_edge == t0[c]) ||
                    ((m_edge >= t0[c] + RD) && (((m_edge - t0[c] - RD) % RP) == 0)));
        end
        for (int c = 0; c < 2; c++) begin
          s_in  = r2[c];
          r2[c] = r1[c];
          r1[c] = raw_now[c];
          for (int k = D - 1; k > 0; k--) win[c][k] = win[c][k-1];
          win[c][0] = s_in;
          if (nfill[c] < D) nfill[c]++;
          all_diff = (nfill[c] == D);
          for (int k = 0; k < D; k++) if (win[c][k] == mdb[c]) all_diff = 1'b0;
          if (all_diff) begin
            t0[c] = s_in ? m_edge + 1 : -1;
          end
        end
        // Masking uses the levels that held before this edge.
        exp_q.push_back({1'b0, vis[0] & ~mdb[1], vis[1] & ~mdb[0],
                         1'b0, 1'b0});
        // Apply debounced level updates after computing the masks.
        for (int c = 0; c < 2; c++) begin
          all_diff = (nfill[c] == D);
          for (int k = 0; k < D; k++) if (win[c][k] == mdb[c]) all_diff = 1'b0;
          if (all_diff) mdb[c] = win[c][0];
        end
        exp_q[exp_q.size()-1][1] = mdb[0];
        exp_q[exp_q.size()-1][0] = mdb[1];
      end
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] exp_v;
  logic [3:0]   act_v;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      act_v = {up_if.pulse, dn_if.pulse, up_if.db, dn_if.db};
      tests_run++;
      if ({up_if.pulse, dn_if.pulse} == 2'b11) begin
        tests_failed++;
        $display("FAIL inc_dec_exclusive t=%0t actual=%b required=not 11", $time,
                 {up_if.pulse, dn_if.pulse});
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty t=%0t actual=%b required=queued entry",
                 $time, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v != exp_v[3:0]) begin
          tests_failed++;
          $display("FAIL cycle_check t=%0t actual={inc_dec,up,dn}=%b required=%b",
                   $time, act_v, exp_v[3:0]);
        end
        if (exp_v[4]) begin
          tests_run++;
          if (up_if.state != IDLE || dn_if.state != IDLE) begin
            tests_failed++;
            $display("FAIL reset_state t=%0t actual=%0d/%0d required=%0d/%0d",
                     $time, up_if.state, dn_if.state, IDLE, IDLE);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit up, input bit dn, input int n);
    up_if.raw = up;
    dn_if.raw = dn;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=still running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int n_seg;
  initial begin
    up_if.raw = 1'b0;
    dn_if.raw = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(0, 0, 5);
    // Clean press
    step(1, 0, 8);
    step(0, 0, 20);
    // Bounce rejection on down, then stable hold
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2);
      step(0, 0, 2);
    end
    step(0, 1, 15);
    step(0, 0, 20);
    // Auto-repeat
    step(1, 0, 40);
    step(0, 0, 20);
    // Mutual exclusion: down pressed while up is held, then released
    step(1, 0, 20);
    step(1, 1, 30);
    step(1, 0, 20);
    step(0, 0, 20);
    // Reset mid-repeat with up still held
    step(1, 0, 25);
    pulse_reset();
    step(1, 0, 25);
    step(0, 0, 20);
    // Short glitch
    step(1, 0, 3);
    step(0, 0, 20);
    // Random activity
    for (int i = 0; i < 250; i++) begin
      n_seg = $urandom_range(1, 25);
      if ($urandom_range(0, 99) < 3) pulse_reset();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n_seg);
    end
    step(0, 0, 30);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
